// File: rtl/branch_resolve_queue_pkg.sv
// Shared branch-predictor types and defaults for the branch resolve queue.
package bp_pkg;

    localparam int BP_IDX_W_DEF  = 4;
    localparam int BRQ_DEPTH_DEF = 4;

    typedef struct packed {
        logic [BP_IDX_W_DEF-1:0] idx;
        logic                    pred_taken;
    } brq_entry_t;

    // Saturating 16-bit increment used by the optional statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/update bundle of the branch resolve queue; slave is the queue side.
interface branch_resolve_queue_if
    import bp_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH_DEF,
    parameter int IDX_W = BP_IDX_W_DEF
) ();

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             mispredict;
    logic [CNT_W-1:0] count;

    modport slave (
        input  pred_valid, pred_idx, pred_taken, res_valid, res_taken,
        output pred_ready, upd_valid, upd_idx, upd_taken, mispredict, count
    );

    modport master (
        output pred_valid, pred_idx, pred_taken, res_valid, res_taken,
        input  pred_ready, upd_valid, upd_idx, upd_taken, mispredict, count
    );

endinterface

// File: rtl/branch_resolve_queue_storage.sv
// Entry array of the branch resolve queue: one write port, asynchronous read, no reset.
module brq_storage
    import bp_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH_DEF,
    parameter int WIDTH = BP_IDX_W_DEF + 1
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the pushed entry at the tail slot.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; emits predictor updates and flushes on mispredict.
// Optional BRQ_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH_DEF,
    parameter int IDX_W = BP_IDX_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    branch_resolve_queue_if.slave bus
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]           stat_resolved,
    output logic [15:0]           stat_mispred
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] occ;
    logic [IDX_W:0]   head_entry;
    logic             res_ok;
    logic             mis;
    logic             push_ok;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             mispredict;

    // A mispredicting resolve discards any push offered in the same cycle.
    assign res_ok  = bus.res_valid & (occ != {CNT_W{1'b0}});
    assign mis     = res_ok & (bus.res_taken != head_entry[0]);
    assign push_ok = bus.pred_valid & bus.pred_ready & ~mis;

    assign bus.pred_ready = (occ != FULL);
    assign bus.count      = occ;
    assign bus.upd_valid  = upd_valid;
    assign bus.upd_idx    = upd_idx;
    assign bus.upd_taken  = upd_taken;
    assign bus.mispredict = mispredict;

    brq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (IDX_W + 1)
    ) u_storage (
        .clock   (clock),
        .wr_en   (push_ok),
        .wr_addr (tail),
        .wr_data ({bus.pred_idx, bus.pred_taken}),
        .rd_addr (head),
        .rd_data (head_entry)
    );

    // Pointers, occupancy and registered update outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head       <= {PTR_W{1'b0}};
            tail       <= {PTR_W{1'b0}};
            occ        <= {CNT_W{1'b0}};
            upd_valid  <= 1'b0;
            upd_idx    <= {IDX_W{1'b0}};
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            upd_valid  <= res_ok;
            mispredict <= mis;
            if (res_ok) begin
                upd_idx   <= head_entry[IDX_W:1];
                upd_taken <= bus.res_taken;
            end
            if (mis) begin
                head <= {PTR_W{1'b0}};
                tail <= {PTR_W{1'b0}};
                occ  <= {CNT_W{1'b0}};
            end else begin
                if (push_ok) begin
                    tail <= tail + PTR_W'(1);
                end
                if (res_ok) begin
                    head <= head + PTR_W'(1);
                end
                case ({push_ok, res_ok})
                    2'b10:   occ <= occ + CNT_W'(1);
                    2'b01:   occ <= occ - CNT_W'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

`ifdef BRQ_STATS_EN
    // Saturating resolve and mispredict statistics.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_resolved <= 16'd0;
            stat_mispred  <= 16'd0;
        end else begin
            if (res_ok) begin
                stat_resolved <= sat_inc16(stat_resolved);
            end
            if (mis) begin
                stat_mispred <= sat_inc16(stat_mispred);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized scoreboard bench for branch_resolve_queue against a queue-based reference model.
module tb_branch_resolve_queue;
    import bp_pkg::*;

    localparam int DEPTH = 4;
    localparam int IDX_W = 4;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic             mis;
    } upd_t;

    logic clock;
    logic reset;

    branch_resolve_queue_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) intf ();

`ifdef BRQ_STATS_EN
    logic [15:0] stat_resolved;
    logic [15:0] stat_mispred;
    logic [15:0] m_stat_res;
    logic [15:0] m_stat_mis;
`endif

    branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (intf)
`ifdef BRQ_STATS_EN
        ,
        .stat_resolved (stat_resolved),
        .stat_mispred  (stat_mispred)
`endif
    );

    int checks = 0;
    int passes = 0;

    brq_entry_t       model_q[$];
    upd_t             exp_q[$];
    logic [IDX_W-1:0] last_idx;
    logic             last_taken;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        last_idx   = '0;
        last_taken = 1'b0;
`ifdef BRQ_STATS_EN
        m_stat_res = 16'd0;
        m_stat_mis = 16'd0;
`endif
    endtask

    // Monitor: every presented update must match the oldest expected one.
    always @(negedge clock) begin
        if (!reset && intf.upd_valid) begin
            if (exp_q.size() == 0) begin
                check("upd_unexpected", 32'd1, 32'd0);
            end else begin
                upd_t e;
                e = exp_q.pop_front();
                check("upd_idx", 32'(intf.upd_idx), 32'(e.idx));
                check("upd_taken", 32'(intf.upd_taken), 32'(e.taken));
                check("mispredict", 32'(intf.mispredict), 32'(e.mis));
            end
        end
    end

    task automatic cycle(input logic pv, input logic [IDX_W-1:0] pidx, input logic pt,
                         input logic rv, input logic rt);
        logic       m_ready;
        logic       m_res;
        logic       m_mis;
        brq_entry_t h;
        @(negedge clock);
        intf.pred_valid = pv;
        intf.pred_idx   = pidx;
        intf.pred_taken = pt;
        intf.res_valid  = rv;
        intf.res_taken  = rt;
        #1;
        m_ready = (model_q.size() != DEPTH);
        check("pred_ready", 32'(intf.pred_ready), 32'(m_ready));
        m_res = rv && (model_q.size() != 0);
        m_mis = 1'b0;
        if (m_res) begin
            h = model_q.pop_front();
            m_mis = (rt != h.pred_taken);
            exp_q.push_back('{h.idx, rt, m_mis});
            last_idx   = h.idx;
            last_taken = rt;
`ifdef BRQ_STATS_EN
            if (m_stat_res != 16'hFFFF) m_stat_res = m_stat_res + 16'd1;
            if (m_mis && m_stat_mis != 16'hFFFF) m_stat_mis = m_stat_mis + 16'd1;
`endif
        end
        if (m_mis) begin
            model_q.delete();
        end else if (pv && m_ready) begin
            model_q.push_back('{pidx, pt});
        end
        @(posedge clock);
        #1;
        check("count", 32'(intf.count), 32'(model_q.size()));
        check("upd_valid", 32'(intf.upd_valid), 32'(m_res));
        check("mispredict_lvl", 32'(intf.mispredict), 32'(m_mis));
        check("upd_idx_hold", 32'(intf.upd_idx), 32'(last_idx));
        check("upd_taken_hold", 32'(intf.upd_taken), 32'(last_taken));
`ifdef BRQ_STATS_EN
        check("stat_resolved", 32'(stat_resolved), 32'(m_stat_res));
        check("stat_mispred", 32'(stat_mispred), 32'(m_stat_mis));
`endif
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic rt;
        reset = 1'b1;
        intf.pred_valid = 1'b0;
        intf.pred_idx   = '0;
        intf.pred_taken = 1'b0;
        intf.res_valid  = 1'b0;
        intf.res_taken  = 1'b0;
        model_reset();
        #1;
        check("rst_count", 32'(intf.count), 32'd0);
        check("rst_upd_valid", 32'(intf.upd_valid), 32'd0);
        check("rst_mispredict", 32'(intf.mispredict), 32'd0);
        check("rst_pred_ready", 32'(intf.pred_ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;

        // 1: single push then correct resolve
        cycle(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        idle();

        // 2: fill, ignored fifth push, drain in order
        cycle(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        idle();

        // 3: mispredict flushes the younger entry
        cycle(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // 4: push dropped alongside a mispredict, then resolve on empty
        cycle(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'd8, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);

        // 5: steady state at count 2 with pointer wrap
        cycle(1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 4'(12 + i), 1'(i), 1'b1, model_q[0].pred_taken);
        end
        cycle(1'b0, 4'd0, 1'b0, 1'b1, model_q[0].pred_taken);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, model_q[0].pred_taken);

        // 6: reset mid-operation with entries pending and an update on the bus
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'(i + 1), 1'b1, 1'b0, 1'b0);
        end
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst_count", 32'(intf.count), 32'd0);
        check("midrst_upd_valid", 32'(intf.upd_valid), 32'd0);
        check("midrst_mispredict", 32'(intf.mispredict), 32'd0);
        check("midrst_pred_ready", 32'(intf.pred_ready), 32'd1);
`ifdef BRQ_STATS_EN
        check("midrst_stat_res", 32'(stat_resolved), 32'd0);
        check("midrst_stat_mis", 32'(stat_mispred), 32'd0);
`endif
        @(negedge clock);
        reset = 1'b0;
        idle();

        // Randomized traffic, mostly correct predictions
        for (int n = 0; n < 400; n++) begin
            if (model_q.size() != 0 && $urandom_range(3, 0) != 0) begin
                rt = model_q[0].pred_taken;
            end else begin
                rt = 1'($urandom);
            end
            cycle(1'($urandom_range(2, 0) != 0), 4'($urandom), 1'($urandom),
                  1'($urandom_range(1, 0)), rt);
        end
        idle();
        idle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
